// File: rtl/cond_pkg.sv
// Shared definitions for the condition-evaluation / flags unit:
// ARM condition codes, flag bit positions, flags_write bits and IT FSM states.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_Q = 4;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_Q  = 2;
  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

  typedef enum logic {
    IT_IDLE,
    IT_ACTIVE
  } it_state_e;

endpackage

// File: rtl/cond_eval.sv
// Pure combinational ARM condition check: 4-bit condition + NZCV -> {pass, undef}.
// Shared with the branch predictor check, so it carries no state.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o,
  output logic       undef_o
);

  logic n, z, c, v, ge, hi, gt;

  always_comb begin
    n  = nzcv_i[FLAG_N];
    z  = nzcv_i[FLAG_Z];
    c  = nzcv_i[FLAG_C];
    v  = nzcv_i[FLAG_V];
    ge = (n == v);
    hi = c & ~z;
    gt = ~z & ge;
    pass_o  = 1'b0;
    undef_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = hi;
      COND_LS: pass_o = ~hi;
      COND_GE: pass_o = ge;
      COND_LT: pass_o = ~ge;
      COND_GT: pass_o = gt;
      COND_LE: pass_o = ~gt;
      COND_AL: pass_o = 1'b1;
      COND_NV: undef_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_it_unit.sv
// Banked {Q,N,Z,C,V} flags register with condition evaluation and a
// Thumb-style IT block tracker that predicates up to IT_MAX following instructions.
module cond_it_unit
  import cond_pkg::*;
#(
  parameter int NUM_BANKS       = 2,
  parameter int BANK_W          = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  parameter int ALU_FLAGS_WIDTH = 5,
  parameter int IT_MAX          = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  input  logic [BANK_W-1:0]          bank_sel_i,
  input  logic [3:0]                 cond_i,
  input  logic [ALU_FLAGS_WIDTH-1:0] alu_flags_i,
  input  logic [2:0]                 flags_write_i,
  input  logic                       q_clear_i,
  input  logic                       it_start_i,
  input  logic [3:0]                 it_firstcond_i,
  input  logic [2:0]                 it_len_i,
  input  logic [3:0]                 it_then_i,
  output logic                       cond_ex_o,
  output logic                       undef_o,
  output logic [ALU_FLAGS_WIDTH-1:0] flags_o,
  output logic                       it_active_o,
  output logic [1:0]                 it_slot_o
);

  logic [ALU_FLAGS_WIDTH-1:0] flags_q [NUM_BANKS];
  logic [ALU_FLAGS_WIDTH-1:0] flags_d [NUM_BANKS];
  it_state_e                  state_q, state_d;
  logic [1:0]                 slot_q, slot_d;
  logic [2:0]                 len_q, len_d;
  logic [3:0]                 fc_q, fc_d;
  logic [3:0]                 then_q, then_d;

  logic                       accept, sel_ok, it_bad, then_bad, ev_pass, ev_undef;
  logic [ALU_FLAGS_WIDTH-1:0] sel_flags, cur;
  logic [3:0]                 eff_cond, slot_cond;

  assign accept = valid_i & ~stall_i;
  assign sel_ok = (int'(bank_sel_i) < NUM_BANKS);

  always_comb begin
    sel_flags = sel_ok ? flags_q[bank_sel_i] : '0;
    slot_cond = then_q[slot_q] ? fc_q : {fc_q[3:1], ~fc_q[0]};
    eff_cond  = (state_q == IT_ACTIVE) ? slot_cond : cond_i;
  end

  cond_eval u_eval (
    .cond_i  (eff_cond),
    .nzcv_i  ({sel_flags[FLAG_N], sel_flags[FLAG_Z], sel_flags[FLAG_C], sel_flags[FLAG_V]}),
    .pass_o  (ev_pass),
    .undef_o (ev_undef)
  );

  // An IT instruction always "executes" unless its encoding is illegal in context
  always_comb begin
    then_bad = 1'b0;
    for (int k = 0; k < IT_MAX; k++) begin
      if (k < int'(it_len_i) && !it_then_i[k]) then_bad = 1'b1;
    end
    it_bad = (state_q == IT_ACTIVE) || (it_len_i == 3'd0) || (int'(it_len_i) > IT_MAX)
             || !it_then_i[0] || (it_firstcond_i == COND_NV)
             || ((it_firstcond_i == COND_AL) && then_bad);
    if (it_start_i) begin
      undef_o   = it_bad;
      cond_ex_o = ~it_bad;
    end else begin
      undef_o   = ev_undef;
      cond_ex_o = ev_pass;
    end
  end

  // Q clear happens before the sticky OR so a same-cycle saturation still sets Q
  always_comb begin
    flags_d = flags_q;
    cur     = '0;
    if (accept && sel_ok) begin
      cur = flags_q[bank_sel_i];
      if (q_clear_i) cur[FLAG_Q] = 1'b0;
      if (cond_ex_o && !undef_o) begin
        if (flags_write_i[FW_NZ]) begin
          cur[FLAG_N] = alu_flags_i[FLAG_N];
          cur[FLAG_Z] = alu_flags_i[FLAG_Z];
        end
        if (flags_write_i[FW_CV]) begin
          cur[FLAG_C] = alu_flags_i[FLAG_C];
          cur[FLAG_V] = alu_flags_i[FLAG_V];
        end
        if (flags_write_i[FW_Q]) cur[FLAG_Q] = cur[FLAG_Q] | alu_flags_i[FLAG_Q];
      end
      flags_d[bank_sel_i] = cur;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    len_d   = len_q;
    fc_d    = fc_q;
    then_d  = then_q;
    if (flush_i) begin
      state_d = IT_IDLE;
      slot_d  = 2'd0;
    end else if (accept) begin
      if (state_q == IT_IDLE) begin
        if (it_start_i && !it_bad) begin
          state_d = IT_ACTIVE;
          slot_d  = 2'd0;
          len_d   = it_len_i;
          fc_d    = it_firstcond_i;
          then_d  = it_then_i;
        end
      end else if (!it_start_i) begin
        if ({1'b0, slot_q} == len_q - 3'd1) begin
          state_d = IT_IDLE;
          slot_d  = 2'd0;
        end else begin
          slot_d = slot_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++) flags_q[b] <= '0;
      state_q <= IT_IDLE;
      slot_q  <= 2'd0;
      len_q   <= 3'd0;
      fc_q    <= 4'd0;
      then_q  <= 4'd0;
    end else begin
      flags_q <= flags_d;
      state_q <= state_d;
      slot_q  <= slot_d;
      len_q   <= len_d;
      fc_q    <= fc_d;
      then_q  <= then_d;
    end
  end

  assign flags_o     = sel_flags;
  assign it_active_o = (state_q == IT_ACTIVE);
  assign it_slot_o   = slot_q;

endmodule
